// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write sequencer: FSM states, o_io_lcd bit map, long-running commands.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ENABLE = 3'd2,
      HOLD   = 3'd3,
      WAIT   = 3'd4
   } lcd_state_e;

   localparam int LCD_ON_BIT  = 31;
   localparam int LCD_REQ_BIT = 10;
   localparam int LCD_RS_BIT  = 9;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear-display and return-home run far longer than every other instruction.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
      return !rs && ((dat == LCD_CMD_CLEAR) || (dat == LCD_CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of {RS,DATA} entries; read data is the head entry, visible combinationally.
// A push while full is accepted only when a pop happens on the same edge.
module lcd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the addresses match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Turns REQ-toggle writes on o_io_lcd into HD44780 bus cycles: setup, EN pulse, hold, execution wait.
// Push one edge after a toggle, pop one edge later; requests arriving at a full FIFO are dropped and flagged.
module lcd_write_sequencer
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int T_SETUP_CYC = 2,
   parameter int T_EN_CYC    = 25,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_EXEC_CYC  = 2000,
   parameter int T_CLEAR_CYC = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_lcd_word,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_busy,
   output logic        o_overflow
);

   localparam int T_MAX = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC),
                                          max_int(T_HOLD_CYC, T_EXEC_CYC)), T_CLEAR_CYC);
   localparam int CW    = $clog2(T_MAX + 1);

   lcd_state_e  state;
   logic [CW-1:0] cnt;
   logic        req_q;
   logic        req;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [8:0]  fifo_dat;
   logic        cnt_last;
   logic        lcd_word_unused;

   assign lcd_word_unused = ^{i_lcd_word[30:11], i_lcd_word[8]};

   assign req      = i_lcd_word[LCD_REQ_BIT] ^ req_q;
   assign fifo_pop = (state == IDLE) && !fifo_empty;
   assign cnt_last = (cnt == CW'(1));
   assign o_busy   = !fifo_empty || (state != IDLE);
   assign o_lcd_rw = 1'b0;

   lcd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .push     (req),
      .push_dat ({i_lcd_word[LCD_RS_BIT], i_lcd_word[7:0]}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_q      <= 1'b0;
         o_lcd_on   <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         req_q    <= i_lcd_word[LCD_REQ_BIT];
         o_lcd_on <= i_lcd_word[LCD_ON_BIT];
         if (req && fifo_full && !fifo_pop) o_overflow <= 1'b1;
      end
   end

   // Every state reloads cnt on entry and leaves when it reaches 1, so it never wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         o_lcd_en   <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_data <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  o_lcd_rs   <= fifo_dat[8];
                  o_lcd_data <= fifo_dat[7:0];
                  cnt        <= CW'(T_SETUP_CYC);
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_last) begin
                  o_lcd_en <= 1'b1;
                  cnt      <= CW'(T_EN_CYC);
                  state    <= ENABLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ENABLE: begin
               if (cnt_last) begin
                  o_lcd_en <= 1'b0;
                  cnt      <= CW'(T_HOLD_CYC);
                  state    <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (cnt_last) begin
                  cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? CW'(T_CLEAR_CYC) : CW'(T_EXEC_CYC);
                  state <= WAIT;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WAIT: begin
               if (cnt_last) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               o_lcd_en <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with short timing overrides; cycle n is the cycle after edge n.
module tb_lcd_write_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] word;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overflow;

   int          n_cmp = 0;
   int          n_err = 0;
   int          pulses = 0;
   logic [8:0]  seen[$];
   logic        en_prev = 1'b0;
   logic        rw_bad = 1'b0;
   logic        req;

   lcd_write_sequencer #(
      .FIFO_DEPTH  (4),
      .T_SETUP_CYC (2),
      .T_EN_CYC    (3),
      .T_HOLD_CYC  (2),
      .T_EXEC_CYC  (5),
      .T_CLEAR_CYC (20)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_lcd_word (word),
      .o_lcd_data (lcd_data),
      .o_lcd_rs   (lcd_rs),
      .o_lcd_rw   (lcd_rw),
      .o_lcd_en   (lcd_en),
      .o_lcd_on   (lcd_on),
      .o_busy     (busy),
      .o_overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: records {RS,DATA} at each EN rise.
   always @(negedge clk) begin
      if (lcd_en && !en_prev) begin
         pulses = pulses + 1;
         seen.push_back({lcd_rs, lcd_data});
      end
      en_prev = lcd_en;
      if (lcd_rw !== 1'b0) rw_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic rs, input logic [7:0] dat);
      req = ~req;
      word[10]  = req;
      word[9]   = rs;
      word[7:0] = dat;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int t;
      t = 0;
      while (busy && t < limit) begin
         tick();
         t++;
      end
      if (busy) check(tag, 32'd1, 32'd0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      word  = 32'h0;
      req   = 1'b0;
      repeat (3) tick();
      check("rst_en",   lcd_en,   0);
      check("rst_busy", busy,     0);
      check("rst_ovf",  overflow, 0);
      check("rst_data", lcd_data, 0);
      check("rst_rs",   lcd_rs,   0);
      check("rst_on",   lcd_on,   0);
      check("rst_rw",   lcd_rw,   0);
      rst_n = 1'b1;
      tick();

      // 1: single function-set write
      req  = 1'b1;
      word = 32'h0000_0438;
      check("t1_busy_c0", busy, 0);
      for (int c = 1; c <= 15; c++) begin
         tick();
         case (c)
            1:  check("t1_busy_c1", busy, 1);
            3:  check("t1_en_c3", lcd_en, 0);
            4: begin
               check("t1_en_c4", lcd_en, 1);
               check("t1_data", lcd_data, 8'h38);
               check("t1_rs", lcd_rs, 0);
            end
            6:  check("t1_en_c6", lcd_en, 1);
            7:  check("t1_en_c7", lcd_en, 0);
            13: check("t1_busy_c13", busy, 1);
            14: check("t1_busy_c14", busy, 0);
            default: ;
         endcase
      end
      check("t1_pulses", pulses, 1);

      // 2: clear display waits 20 cycles, data write queued behind it waits 5
      send(1'b0, 8'h01);
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (c == 1) send(1'b1, 8'h41);
         case (c)
            4:  check("t2_clr_data", lcd_data, 8'h01);
            28: check("t2_en_c28", lcd_en, 0);
            29: check("t2_data_c29", lcd_data, 8'h01);
            30: begin
               check("t2_data_c30", lcd_data, 8'h41);
               check("t2_rs_c30", lcd_rs, 1);
            end
            31: check("t2_en_c31", lcd_en, 0);
            32: check("t2_en_c32", lcd_en, 1);
            41: check("t2_busy_c41", busy, 1);
            42: check("t2_busy_c42", busy, 0);
            default: ;
         endcase
      end
      check("t2_pulses", pulses, 3);

      // 3: six back-to-back toggles, sixth finds the FIFO full
      base = pulses;
      seen.delete();
      for (int i = 0; i < 6; i++) begin
         send(1'b1, 8'(8'h10 + i));
         tick();
         if (i == 4) check("t3_ovf_before", overflow, 0);
      end
      tick();
      check("t3_ovf_after", overflow, 1);
      wait_idle("t3_timeout", 200);
      check("t3_pulses", pulses - base, 5);
      check("t3_seen_n", seen.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < seen.size()) check("t3_order", seen[k], {1'b1, 8'(8'h10 + k)});

      // 4: reset mid EN pulse
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 8'(8'h50 + i));
         tick();
      end
      begin
         int t;
         t = 0;
         while (!lcd_en && t < 50) begin
            tick();
            t++;
         end
      end
      check("t4_en_seen", lcd_en, 1);
      #2;
      rst_n    = 1'b0;
      req      = 1'b0;
      word[10] = 1'b0;
      #1;
      check("t4_en_async", lcd_en, 0);
      check("t4_busy", busy, 0);
      check("t4_ovf", overflow, 0);
      base = pulses;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (60) tick();
      check("t4_no_pulse", pulses, base);
      check("t4_busy_after", busy, 0);

      // 5: ON bit alone
      base = pulses;
      word[31] = 1'b1;
      check("t5_on_c0", lcd_on, 0);
      tick();
      check("t5_on_c1", lcd_on, 1);
      check("t5_en", lcd_en, 0);
      check("t5_busy", busy, 0);
      word[31] = 1'b0;
      tick();
      check("t5_on_off", lcd_on, 0);
      check("t5_no_pulse", pulses, base);

      // 6: push while full on the same edge as the IDLE pop
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_ovf_rst", overflow, 0);
      base = pulses;
      seen.delete();
      send(1'b1, 8'h20);
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c <= 4) send(1'b1, 8'(8'h20 + c));
         if (c == 14) send(1'b1, 8'h25);
      end
      tick();
      check("t6_ovf_edge", overflow, 0);
      wait_idle("t6_timeout", 200);
      check("t6_pulses", pulses - base, 6);
      check("t6_seen_n", seen.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < seen.size()) check("t6_order", seen[k], {1'b1, 8'(8'h20 + k)});
      check("t6_ovf_end", overflow, 0);
      check("rw_low", rw_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
